// File: rtl/clock_time_counter.sv
// Timekeeping core: divides clk to a 1 Hz tick and keeps a 24-hour HH:MM:SS count.
// Load overrides the tick on the same edge; all strobes are registered single-cycle pulses.
module clock_time_counter #(
    parameter int unsigned TICK_DIV   = 50_000_000,
    parameter int unsigned RESET_HOUR = 0,
    parameter int unsigned RESET_MIN  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       count_en,
    input  logic       load_en,
    input  logic [4:0] load_hour,
    input  logic [5:0] load_min,
    output logic [4:0] hour,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       sec_tick,
    output logic       min_carry,
    output logic       day_carry
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [4:0]    hour_d;
    logic [5:0]    min_d, sec_d;
    logic          sec_tick_d, min_carry_d, day_carry_d;
    logic          tick_int;

    assign tick_int = count_en && (presc_q == PRESC_LAST);

    always_comb begin
        presc_d     = presc_q;
        hour_d      = hour;
        min_d       = min;
        sec_d       = sec;
        sec_tick_d  = 1'b0;
        min_carry_d = 1'b0;
        day_carry_d = 1'b0;

        if (load_en) begin
            // A coincident tick is dropped, and out-of-range load values fall back to zero.
            presc_d = '0;
            hour_d  = (load_hour > 5'd23) ? 5'd0 : load_hour;
            min_d   = (load_min > 6'd59) ? 6'd0 : load_min;
            sec_d   = '0;
        end else if (tick_int) begin
            presc_d    = '0;
            sec_tick_d = 1'b1;
            if (sec < 6'd59) begin
                sec_d = sec + 6'd1;
            end else begin
                sec_d       = '0;
                min_carry_d = 1'b1;
                if (min < 6'd59) begin
                    min_d = min + 6'd1;
                end else begin
                    min_d = '0;
                    if (hour < 5'd23) begin
                        hour_d = hour + 5'd1;
                    end else begin
                        hour_d      = '0;
                        day_carry_d = 1'b1;
                    end
                end
            end
        end else if (count_en) begin
            presc_d = presc_q + PW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q   <= '0;
            hour      <= 5'(RESET_HOUR);
            min       <= 6'(RESET_MIN);
            sec       <= '0;
            sec_tick  <= 1'b0;
            min_carry <= 1'b0;
            day_carry <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            hour      <= hour_d;
            min       <= min_d;
            sec       <= sec_d;
            sec_tick  <= sec_tick_d;
            min_carry <= min_carry_d;
            day_carry <= day_carry_d;
        end
    end

endmodule

// File: tb/tb_clock_time_counter.sv
// Directed bench for clock_time_counter with TICK_DIV=4: load vector table plus
// hand-written reset, free-run, day-wrap, freeze and load-vs-tick sequences.
module tb_clock_time_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       count_en;
    logic       load_en;
    logic [4:0] load_hour;
    logic [5:0] load_min;
    logic [4:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
    logic       sec_tick;
    logic       min_carry;
    logic       day_carry;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int ce;
        int lh;
        int lm;
        int eh;
        int em;
    } vec_t;

    vec_t vecs[7];

    clock_time_counter #(
        .TICK_DIV  (4),
        .RESET_HOUR(0),
        .RESET_MIN (0)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .count_en (count_en),
        .load_en  (load_en),
        .load_hour(load_hour),
        .load_min (load_min),
        .hour     (hour),
        .min      (min),
        .sec      (sec),
        .sec_tick (sec_tick),
        .min_carry(min_carry),
        .day_carry(day_carry)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check($sformatf("%s hour", tag), int'(hour), h);
        check($sformatf("%s min", tag), int'(min), m);
        check($sformatf("%s sec", tag), int'(sec), s);
    endtask

    task automatic check_strobes(input string tag, input int st, input int mc, input int dc);
        check($sformatf("%s sec_tick", tag), int'(sec_tick), st);
        check($sformatf("%s min_carry", tag), int'(min_carry), mc);
        check($sformatf("%s day_carry", tag), int'(day_carry), dc);
    endtask

    task automatic do_load(input int h, input int m);
        load_hour = 5'(h);
        load_min  = 6'(m);
        load_en   = 1'b1;
        step();
        load_en   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int first_tick;
        int ticks;
        int carries;
        int carry_at;
        int carry_sec;
        int spacing_err;
        int days;
        int strobes;

        vecs = '{
            '{1, 7, 45, 7, 45},
            '{0, 30, 63, 0, 0},
            '{1, 23, 59, 23, 59},
            '{0, 24, 60, 0, 0},
            '{1, 31, 0, 0, 0},
            '{0, 12, 30, 12, 30},
            '{1, 0, 59, 0, 59}
        };

        rst       = 1'b1;
        count_en  = 1'b0;
        load_en   = 1'b0;
        load_hour = '0;
        load_min  = '0;
        #12;
        check_time("reset", 0, 0, 0);
        check_strobes("reset", 0, 0, 0);
        rst = 1'b0;

        // Reach 05:10:30, then pulse reset mid-second between clock edges.
        do_load(5, 10);
        count_en = 1'b1;
        repeat (120) step();
        check_time("pre-rst", 5, 10, 30);
        repeat (2) step();
        #2 rst = 1'b1;
        #1;
        check_time("async rst", 0, 0, 0);
        check_strobes("async rst", 0, 0, 0);
        step();
        rst = 1'b0;
        first_tick = 0;
        for (int i = 1; i <= 8; i++) begin
            step();
            if (sec_tick && first_tick == 0) first_tick = i;
        end
        check("first tick latency", first_tick, 4);

        // Free run 240 clk from 00:00:00.
        rst = 1'b1;
        step();
        rst = 1'b0;
        ticks = 0; carries = 0; carry_at = 0; carry_sec = -1; spacing_err = 0; days = 0;
        for (int i = 1; i <= 240; i++) begin
            step();
            if (sec_tick) begin
                ticks++;
                if (i % 4 != 0) spacing_err++;
            end
            if (min_carry) begin
                carries++;
                carry_at  = i;
                carry_sec = int'(sec);
            end
            if (day_carry) days++;
        end
        check("run tick count", ticks, 60);
        check("run tick spacing", spacing_err, 0);
        check("run carry count", carries, 1);
        check("run carry cycle", carry_at, 240);
        check("run carry sec", carry_sec, 0);
        check("run day count", days, 0);
        check_time("run", 0, 1, 0);

        // Load table, alternating count_en.
        for (int v = 0; v < 7; v++) begin
            count_en = vecs[v].ce[0];
            do_load(vecs[v].lh, vecs[v].lm);
            check_time($sformatf("load%0d", v), vecs[v].eh, vecs[v].em, 0);
            check_strobes($sformatf("load%0d", v), 0, 0, 0);
        end

        // Day wrap from 23:59:00.
        count_en = 1'b1;
        do_load(23, 59);
        days = 0;
        for (int i = 1; i <= 240; i++) begin
            step();
            if (day_carry) days++;
        end
        check_time("day wrap", 0, 0, 0);
        check_strobes("day wrap", 1, 1, 1);
        check("day carry count", days, 1);
        step();
        check_strobes("after wrap", 0, 0, 0);

        // Freeze with prescaler at 2.
        do_load(0, 0);
        repeat (2) step();
        count_en = 1'b0;
        strobes = 0;
        repeat (100) begin
            step();
            if (sec_tick || min_carry || day_carry) strobes++;
        end
        check("freeze strobes", strobes, 0);
        check_time("freeze", 0, 0, 0);
        count_en = 1'b1;
        step();
        check("resume tick early", int'(sec_tick), 0);
        step();
        check("resume tick", int'(sec_tick), 1);
        check("resume sec", int'(sec), 1);

        // Load on the terminal prescaler cycle discards the tick.
        do_load(0, 0);
        repeat (3) step();
        do_load(7, 45);
        check_time("load vs tick", 7, 45, 0);
        check_strobes("load vs tick", 0, 0, 0);
        ticks = 0;
        repeat (3) begin
            step();
            if (sec_tick) ticks++;
        end
        check("post-load early ticks", ticks, 0);
        step();
        check("post-load tick", int'(sec_tick), 1);
        check_time("post-load", 7, 45, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
